inv_mix_columns_seq: RTL and testbench
======================================

# inv_mix_columns_seq

Iterative AES InvMixColumns engine for the decrypt datapath; it is the inverse of the combinational `mix_columns` used on the encrypt side. It accepts one 128-bit state per handshake and processes one column per clock, or two columns per clock when `INV_MIX_COLUMNS_DUAL_EN` is defined. The result is held under a valid/ready handshake until the downstream decrypt round logic consumes it.

## Interface
- No parameters. Column width, state width and the GF(2^8) polynomial are fixed.
- `clk`  in  1  system clock; rising-edge active.
- `n_rst`  in  1  asynchronous, active-low reset.
- `i_data`  in  128  state input. Byte 0 is `[127:120]`. Column c occupies `[127-32c -: 32]`, with row 0 in the MSB byte.
- `i_valid`  in  1  `i_data` is presented.
- `o_ready`  out  1  engine can accept an input this cycle.
- `o_data`  out  128  InvMixColumns result, same byte layout as `i_data`.
- `o_valid`  out  1  `o_data` holds a complete result.
- `i_ready`  in  1  downstream consumes `o_data` this cycle.

## Operation
- Per column (a0..a3, row 0 first), arithmetic in GF(2^8) mod 0x11B:
  - b0 = 0e·a0 ^ 0b·a1 ^ 0d·a2 ^ 09·a3
  - b1 = 09·a0 ^ 0e·a1 ^ 0b·a2 ^ 0d·a3
  - b2 = 0d·a0 ^ 09·a1 ^ 0e·a2 ^ 0b·a3
  - b3 = 0b·a0 ^ 0d·a1 ^ 09·a2 ^ 0e·a3
- Multiplies are built from xtime chains (x2, x4, x8). No lookup ROMs. All intermediates are 8-bit.
- Registers:
  - 128-bit input capture register.
  - 128-bit output register.
  - 2-bit column counter `col`.
  - State register.
- States:
  - IDLE
    - `o_ready`=1.
    - On `i_valid`: capture `i_data`, set `col`=0, go to CALC.
  - CALC
    - `o_ready`=0.
    - Each cycle, compute column `col` from the capture register and write it into the same column slot of the output register; `col`++.
    - After column 3 is written, go to DONE.
  - DONE
    - `o_valid`=1 and `o_ready` = `i_ready` (combinational path is intended).
    - `i_ready` and `i_valid`: capture the new input, `col`=0, go to CALC.
    - `i_ready` only: go to IDLE.
    - Otherwise: hold.
- `i_data` is ignored outside an accepting cycle. The capture register is the only data source during CALC.
- Output-register columns not yet rewritten in CALC keep their old values. `o_valid` is 0 throughout CALC, so these stale values are never flagged valid.

## Timing
- Reset values: state IDLE, `col`=0, `o_data`=128'h0, `o_valid`=0. `o_ready` is 1 from the IDLE decode.
- Accept edge k (`i_valid` & `o_ready` sampled high):
  - Column c is written at edge k+1+c.
  - `o_valid` rises after edge k+4, so latency is 4 cycles.
- Back-to-back throughput: one block per 5 cycles, using the DONE→CALC direct transition.
- While `o_valid`=1 and `i_ready`=0, `o_data` and `o_valid` are stable.
- An `i_ready` pulse while not in DONE has no effect.
- Reset asserted mid-CALC or in DONE:
  - Immediate (asynchronous) return to reset values.
  - The in-flight block is dropped; nothing is emitted after reset deasserts.
- `i_valid` during CALC is not accepted. The source holds it per handshake rules.

## Configuration
- `INV_MIX_COLUMNS_DUAL_EN` defined:
  - Two column datapaths; CALC writes columns {0,1}, then {2,3}.
  - `col` steps by 2; latency is 2 cycles; back-to-back is one block per 3 cycles.
- `INV_MIX_COLUMNS_DUAL_EN` undefined: single datapath, 4-cycle latency as above.
- The interface and handshake are identical in both builds.

## Test plan
- Reset with no stimulus:
  - `o_data`=0, `o_valid`=0, `o_ready`=1.
  - Remains so for 10 cycles.
- FIPS-197 vector:
  - Input `i_data`=8e4da1bc_9fdc589d_01010101_d5d5d7d6 with `i_ready`=1.
  - Required: `o_data`=db135345_f20a225c_01010101_d4d4d4d5, `o_valid` high exactly 4 cycles after accept (2 with DUAL).
- Backpressure:
  - Hold `i_ready`=0 for 7 cycles after `o_valid`; `o_data` must stay constant and `o_ready` must stay 0.
  - Raise `i_ready`; `o_valid` falls the next cycle.
- Back-to-back and round trip:
  - Stream the 500 input/output pairs from the encrypt mixColumn vector file, feeding each expected output as `i_data` with `i_valid` held high and `i_ready`=1.
  - Required: each result equals the original input, at one block per 5 cycles (3 with DUAL).
- Fixed points:
  - 01010101 repeated ×4 maps to itself.
  - c6c6c6c6 repeated ×4 maps to itself.
  - All-zero input yields all-zero output.
- Reset mid-operation:
  - Assert `n_rst` two cycles after accept; outputs go to reset values immediately.
  - After release, no `o_valid` appears until a new block is accepted.

Source files
------------

// File: rtl/inv_mix_columns_seq.sv
// Iterative AES InvMixColumns engine, one column per clock behind a valid/ready handshake.
// Define INV_MIX_COLUMNS_DUAL_EN to process two columns per clock.
module inv_mix_columns_seq (
    input  logic         clk,
    input  logic         n_rst,
    input  logic [127:0] i_data,
    input  logic         i_valid,
    output logic         o_ready,
    output logic [127:0] o_data,
    output logic         o_valid,
    input  logic         i_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

`ifdef INV_MIX_COLUMNS_DUAL_EN
    localparam logic [1:0] STEP = 2'd2;
    localparam logic [1:0] LAST = 2'd2;
`else
    localparam logic [1:0] STEP = 2'd1;
    localparam logic [1:0] LAST = 2'd3;
`endif

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // k selects which of a, 2a, 4a, 8a are summed; only 09/0b/0d/0e are used
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] k);
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        x2 = xt(a);
        x4 = xt(x2);
        x8 = xt(x4);
        return ({8{k[3]}} & x8) ^ ({8{k[2]}} & x4)
             ^ ({8{k[1]}} & x2) ^ ({8{k[0]}} & a);
    endfunction

    function automatic logic [31:0] inv_col(input logic [31:0] c);
        logic [7:0] a0;
        logic [7:0] a1;
        logic [7:0] a2;
        logic [7:0] a3;
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] b2;
        logic [7:0] b3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        b0 = gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^ gmul(a2, 4'hd) ^ gmul(a3, 4'h9);
        b1 = gmul(a0, 4'h9) ^ gmul(a1, 4'he) ^ gmul(a2, 4'hb) ^ gmul(a3, 4'hd);
        b2 = gmul(a0, 4'hd) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'he) ^ gmul(a3, 4'hb);
        b3 = gmul(a0, 4'hb) ^ gmul(a1, 4'hd) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'he);
        return {b0, b1, b2, b3};
    endfunction

    state_t        state;
    state_t        state_d;
    logic [1:0]    col;
    logic [127:0]  cap;
    logic [127:0]  out_q;
    logic          load;
    logic [31:0]   cin [4];
    logic [31:0]   res_a;

    assign cin[0] = cap[127:96];
    assign cin[1] = cap[95:64];
    assign cin[2] = cap[63:32];
    assign cin[3] = cap[31:0];

    assign res_a = inv_col(cin[col]);

`ifdef INV_MIX_COLUMNS_DUAL_EN
    logic [31:0] res_b;
    assign res_b = inv_col(cin[{col[1], 1'b1}]);
`endif

    always_comb begin
        state_d = state;
        o_ready = 1'b0;
        o_valid = 1'b0;
        load    = 1'b0;
        unique case (state)
            IDLE: begin
                o_ready = 1'b1;
                if (i_valid) begin
                    load    = 1'b1;
                    state_d = CALC;
                end
            end
            CALC: begin
                if (col == LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                o_valid = 1'b1;
                o_ready = i_ready;
                if (i_ready) begin
                    if (i_valid) begin
                        load    = 1'b1;
                        state_d = CALC;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
            col   <= 2'd0;
            cap   <= 128'h0;
        end else begin
            state <= state_d;
            if (load) begin
                cap <= i_data;
                col <= 2'd0;
            end else if (state == CALC) begin
                col <= col + STEP;
            end
        end
    end

    // Unwritten columns keep stale data; o_valid stays low until all are fresh
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            out_q <= 128'h0;
        end else if (state == CALC) begin
`ifdef INV_MIX_COLUMNS_DUAL_EN
            if (col[1]) begin
                out_q[63:0] <= {res_a, res_b};
            end else begin
                out_q[127:64] <= {res_a, res_b};
            end
`else
            case (col)
                2'd0: out_q[127:96] <= res_a;
                2'd1: out_q[95:64]  <= res_a;
                2'd2: out_q[63:32]  <= res_a;
                default: out_q[31:0] <= res_a;
            endcase
`endif
        end
    end

    assign o_data = out_q;

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// Self-checking bench for inv_mix_columns_seq: vectors, random blocks, streaming round trip.
// Reference model uses a generic GF(2^8) shift-and-add multiply and circulant coefficient rows.
module tb_inv_mix_columns_seq;

`ifdef INV_MIX_COLUMNS_DUAL_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 4;
`endif
    localparam int NSTREAM = 500;

    logic         clk;
    logic         n_rst;
    logic [127:0] i_data;
    logic         i_valid;
    logic         o_ready;
    logic [127:0] o_data;
    logic         o_valid;
    logic         i_ready;

    int passed;
    int total;

    inv_mix_columns_seq dut (
        .clk     (clk),
        .n_rst   (n_rst),
        .i_data  (i_data),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .o_data  (o_data),
        .o_valid (o_valid),
        .i_ready (i_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] din;
        logic [127:0] dout;
    } vec_t;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    // Each output row r is sum over j of m[(j - r) mod 4] * a_j
    function automatic logic [127:0] ref_mix(input logic [127:0] s, input bit inv);
        logic [7:0] m [4];
        logic [7:0] a [16];
        logic [7:0] b;
        logic [127:0] r;
        if (inv) begin
            m[0] = 8'h0e; m[1] = 8'h0b; m[2] = 8'h0d; m[3] = 8'h09;
        end else begin
            m[0] = 8'h02; m[1] = 8'h03; m[2] = 8'h01; m[3] = 8'h01;
        end
        for (int i = 0; i < 16; i++) a[i] = s[127 - 8 * i -: 8];
        r = 128'h0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                b = 8'h00;
                for (int j = 0; j < 4; j++)
                    b = b ^ gf_mul(m[(j - row + 4) % 4], a[4 * c + j]);
                r[127 - 8 * (4 * c + row) -: 8] = b;
            end
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a block, wait for the result; leaves it unconsumed in DONE
    task automatic send(input logic [127:0] din, input string name);
        int n;
        n = 0;
        i_data  = din;
        i_valid = 1'b1;
        while (!o_ready && n < 20) begin
            tick();
            n++;
        end
        check({name, "_ready_to"}, 128'(n < 20), 128'(1));
        tick();
        i_valid = 1'b0;
        i_data  = 128'h0;
        n = 0;
        while (!o_valid && n < 20) begin
            tick();
            n++;
        end
        check({name, "_lat"}, 128'(n), 128'(LAT));
    endtask

    task automatic consume();
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
    endtask

    vec_t         tbl [6];
    logic [127:0] x [NSTREAM];
    logic [127:0] held;
    logic [127:0] rnd;
    int           bad;
    int           in_idx;
    int           out_idx;
    int           cyc;
    int           last_cyc;
    int           gap_bad;
    bit           acc;
    bit           ov;
    logic [127:0] od;

    initial begin
        passed  = 0;
        total   = 0;
        n_rst   = 1'b0;
        i_data  = 128'h0;
        i_valid = 1'b0;
        i_ready = 1'b0;

        tbl[0] = '{128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6,
                   128'hdb135345_f20a225c_01010101_d4d4d4d5};
        tbl[1] = '{{4{32'h01010101}}, {4{32'h01010101}}};
        tbl[2] = '{{4{32'hc6c6c6c6}}, {4{32'hc6c6c6c6}}};
        tbl[3] = '{128'h0, 128'h0};
        tbl[4] = '{{4{32'h4d7ebdf8}}, {4{32'h2d26314c}}};
        tbl[5] = '{128'hd4d4d4d5_8e4da1bc_4d7ebdf8_f20a225c,
                   ref_mix(128'hd4d4d4d5_8e4da1bc_4d7ebdf8_f20a225c, 1'b1)};

        repeat (3) tick();
        n_rst = 1'b1;

        for (int i = 0; i < 10; i++) begin
            check("reset_state", {o_data[127:2], o_valid, o_ready} | 128'(o_data[1:0] != 2'b00) << 2,
                  128'h1);
            tick();
        end

        // model sanity against the published column
        check("model_fips", ref_mix(tbl[0].din, 1'b1), tbl[0].dout);

        for (int i = 0; i < 6; i++) begin
            send(tbl[i].din, $sformatf("vec%0d", i));
            check($sformatf("vec%0d_data", i), o_data, tbl[i].dout);
            consume();
            check($sformatf("vec%0d_drop", i), 128'(o_valid), 128'(0));
        end

        // backpressure: result and handshake frozen while downstream stalls
        send(tbl[0].din, "bp");
        held = o_data;
        bad = 0;
        for (int i = 0; i < 7; i++) begin
            if (o_data !== held || o_ready !== 1'b0 || o_valid !== 1'b1) bad++;
            tick();
        end
        check("bp_stable", 128'(bad), 128'(0));
        check("bp_data", o_data, tbl[0].dout);
        consume();
        check("bp_release", 128'(o_valid), 128'(0));

        // i_ready pulse outside DONE is ignored
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        check("stray_ready", {126'h0, o_valid, o_ready}, 128'h1);

        for (int i = 0; i < 20; i++) begin
            rnd = {$urandom, $urandom, $urandom, $urandom};
            send(rnd, "rnd");
            check($sformatf("rnd%0d_data", i), o_data, ref_mix(rnd, 1'b1));
            consume();
        end

        // streaming round trip: feed MixColumns(x), expect x back
        for (int i = 0; i < NSTREAM; i++) x[i] = {$urandom, $urandom, $urandom, $urandom};
        in_idx   = 0;
        out_idx  = 0;
        cyc      = 0;
        last_cyc = 0;
        gap_bad  = 0;
        i_ready  = 1'b1;
        i_valid  = 1'b1;
        i_data   = ref_mix(x[0], 1'b0);
        while (out_idx < NSTREAM && cyc < NSTREAM * 8) begin
            acc = i_valid && o_ready;
            ov  = o_valid;
            od  = o_data;
            tick();
            cyc++;
            if (ov) begin
                check($sformatf("rt%0d", out_idx), od, x[out_idx]);
                if (out_idx > 0 && cyc - last_cyc != LAT + 1) gap_bad++;
                last_cyc = cyc;
                out_idx++;
            end
            if (acc) begin
                in_idx++;
                if (in_idx < NSTREAM) i_data = ref_mix(x[in_idx], 1'b0);
                else i_valid = 1'b0;
            end
        end
        check("rt_count", 128'(out_idx), 128'(NSTREAM));
        check("rt_throughput", 128'(gap_bad), 128'(0));
        i_valid = 1'b0;
        i_ready = 1'b0;
        repeat (2) tick();

        // reset mid-operation drops the block
        i_data  = tbl[0].din;
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        tick();
        tick();
        n_rst = 1'b0;
        #1;
        check("midrst_vals", {o_data[127:2], o_valid, o_ready} | 128'(o_data[1:0] != 2'b00) << 2,
              128'h1);
        tick();
        n_rst = 1'b1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (o_valid !== 1'b0) bad++;
            tick();
        end
        check("midrst_quiet", 128'(bad), 128'(0));
        send(tbl[4].din, "post_rst");
        check("post_rst_data", o_data, tbl[4].dout);
        consume();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
